// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX control fields and
// the data-memory handshake going in, per-register stall/flush strobes out.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_mr;
  logic [4:0] ex_regdest;
  logic       ex_br_taken;
  logic       ex_j;
  logic       ex_jr;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_redirect;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_hold;
  logic       memwb_bubble;

  // datapath side: presents pipeline status, consumes strobes
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mr, ex_regdest,
           ex_br_taken, ex_j, ex_jr, mem_req, mem_ready,
    input  pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
           pipe_hold, memwb_bubble
  );

  // controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mr, ex_regdest,
           ex_br_taken, ex_j, ex_jr, mem_req, mem_ready,
    output pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
           pipe_hold, memwb_bubble
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage core: load-use stalls, memory-wait
// freeze with watchdog, wrong-path squash on redirects, and saturating
// stall/flush event counters. Strobes are combinational; state is registered.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  input  logic             clr_cnt,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2,
    ERR_X    = 2'd3
  } state_e;

  localparam int               WW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]    TO_W = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             to_q, to_d;

  logic mem_stall, redirect, load_use, rs1_hit, rs2_hit;
  logic hold, take_run, stall_inc, flush_inc;

  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign redirect  = hz.ex_br_taken | hz.ex_j | hz.ex_jr;
  assign rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_regdest);
  assign rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_regdest);
  // x0 is never a real producer, so it cannot create a hazard
  assign load_use  = hz.ex_mr & (hz.ex_regdest != 5'd0) & (rs1_hit | rs2_hit);

  // next-state selection: freeze (hold) vs normal RUN evaluation (take_run)
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    to_d      = to_q;
    hold      = 1'b0;
    take_run  = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          // redirect ignored: EX is frozen and re-presents it on exit
          hold      = 1'b1;
          stall_inc = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = WW'(1);
        end else begin
          take_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          // completing cycle acts like RUN and is not a stall cycle
          take_run = 1'b1;
          state_d  = RUN;
          wait_d   = '0;
        end else begin
          hold      = 1'b1;
          stall_inc = 1'b1;
          if (TIMEOUT != 0 && wait_q == TO_W) begin
            state_d = ERROR;
            to_d    = 1'b1;
          end else if (wait_q < TO_W) begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      default: begin
        // ERROR and the unused encoding: frozen until reset
        hold    = 1'b1;
        state_d = ERROR;
      end
    endcase
    flush_inc = take_run & redirect;
    // load-use under a redirect is moot: the ID instruction is squashed
    if (take_run & ~redirect & load_use) stall_inc = 1'b1;
  end

  // strobe generation, with reset forcing a flushed, non-advancing pipe
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.pc_redirect  = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_flush   = 1'b0;
    hz.pipe_hold    = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (!reset) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (hold) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.pipe_hold    = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (take_run & redirect) begin
      hz.pc_redirect = 1'b1;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
    end else if (take_run & load_use) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  // saturating event counters; clear wins over increment
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_inc && stall_q != CMAX) stall_d = stall_q + 1'b1;
      if (flush_inc && flush_q != CMAX) flush_d = flush_q + 1'b1;
    end
  end

  // state, watchdog and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      to_q    <= to_d;
    end
  end

  assign state       = state_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign mem_timeout = to_q | state_q[1];
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (short watchdog + 2-bit counters, and
// disabled watchdog + 8-bit counters) see identical stimulus; a behavioural
// model predicts each cycle's outputs, a negedge monitor compares.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, jj, jr, req, rdy;

  hazard_ctrl_if if0 ();
  hazard_ctrl_if if1 ();

  assign if0.id_rs1 = rs1;  assign if1.id_rs1 = rs1;
  assign if0.id_rs2 = rs2;  assign if1.id_rs2 = rs2;
  assign if0.id_use_rs1 = u1; assign if1.id_use_rs1 = u1;
  assign if0.id_use_rs2 = u2; assign if1.id_use_rs2 = u2;
  assign if0.ex_mr = mr;    assign if1.ex_mr = mr;
  assign if0.ex_regdest = rd; assign if1.ex_regdest = rd;
  assign if0.ex_br_taken = br; assign if1.ex_br_taken = br;
  assign if0.ex_j = jj;     assign if1.ex_j = jj;
  assign if0.ex_jr = jr;    assign if1.ex_jr = jr;
  assign if0.mem_req = req; assign if1.mem_req = req;
  assign if0.mem_ready = rdy; assign if1.mem_ready = rdy;

  logic       mt0, mt1;
  logic [1:0] st0, st1;
  logic [1:0] sc0, fc0;
  logic [7:0] sc1, fc1;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .hz(if0.slave), .clr_cnt(clr),
    .mem_timeout(mt0), .state(st0), .stall_cnt(sc0), .flush_cnt(fc0));
  hazard_ctrl #(.TIMEOUT(0), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(rst_n), .hz(if1.slave), .clr_cnt(clr),
    .mem_timeout(mt1), .state(st1), .stall_cnt(sc1), .flush_cnt(fc1));

  // strb = {pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
  //         pipe_hold, memwb_bubble, mem_timeout}
  typedef struct packed {
    logic [7:0]  strb;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  // mode: 0 running, 1 waiting on memory, 2 dead
  typedef struct { int mode; int waited; int stalls; int flushes; bit tout; } mst_t;

  exp_t q0[$], q1[$];
  mst_t m0, m1;
  int   total = 0, bad = 0;

  // predict this cycle's outputs from the rules, then advance the model
  function automatic exp_t mstep(input int tlim, input int cmax, inout mst_t m);
    exp_t e;
    bit   ms, rdr, lu, stuck;
    int   ds, df;
    ms  = req && !rdy;
    rdr = br || jj || jr;
    lu  = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    ds = 0; df = 0;
    if (!rst_n) begin
      m = '{0, 0, 0, 0, 0};
      e.strb = 8'b0001_1000; e.st = '0; e.sc = '0; e.fc = '0;
      return e;
    end
    e.st = 2'(m.mode); e.sc = 16'(m.stalls); e.fc = 16'(m.flushes);
    if (m.mode == 2) begin
      e.strb = 8'b0000_0111;
    end else begin
      stuck = (m.mode == 1) ? !rdy : ms;
      if (stuck) begin
        e.strb = 8'b0000_0110; ds = 1;
        if (m.mode == 0) begin m.mode = 1; m.waited = 1; end
        else if (tlim != 0 && m.waited == tlim) begin m.mode = 2; m.tout = 1; end
        else m.waited = (m.waited + 1 > tlim) ? tlim : m.waited + 1;
      end else begin
        m.mode = 0; m.waited = 0;
        if (rdr)     begin e.strb = 8'b1111_1000; df = 1; end
        else if (lu) begin e.strb = 8'b0000_1000; ds = 1; end
        else         e.strb = 8'b1010_0000;
      end
    end
    if (clr) begin m.stalls = 0; m.flushes = 0; end
    else begin
      m.stalls  = (m.stalls + ds > cmax) ? cmax : m.stalls + ds;
      m.flushes = (m.flushes + df > cmax) ? cmax : m.flushes + df;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // monitor: compare DUT outputs to the oldest prediction mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("strb0", {8'h0, if0.pc_write, if0.pc_redirect, if0.ifid_write, if0.ifid_flush,
                   if0.idex_flush, if0.pipe_hold, if0.memwb_bubble, mt0}, {8'h0, e.strb});
      chk("state0", {14'h0, st0}, {14'h0, e.st});
      chk("stall0", {14'h0, sc0}, e.sc);
      chk("flush0", {14'h0, fc0}, e.fc);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("strb1", {8'h0, if1.pc_write, if1.pc_redirect, if1.ifid_write, if1.ifid_flush,
                   if1.idex_flush, if1.pipe_hold, if1.memwb_bubble, mt1}, {8'h0, e.strb});
      chk("state1", {14'h0, st1}, {14'h0, e.st});
      chk("stall1", {8'h0, sc1}, e.sc);
      chk("flush1", {8'h0, fc1}, e.fc);
    end
  end

  task automatic step();
    q0.push_back(mstep(4, 3, m0));
    q1.push_back(mstep(0, 255, m1));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; mr = 0;
    br = 0; jj = 0; jr = 0; req = 0; rdy = 0; clr = 0;
  endtask

  initial begin
    m0 = '{0, 0, 0, 0, 0}; m1 = '{0, 0, 0, 0, 0};
    idle(); rst_n = 0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1; step();
    // load-use on rs2, then released
    mr = 1; rd = 5; rs2 = 5; u2 = 1; step();
    mr = 0; step();
    // x0 destination, then unused source
    idle(); mr = 1; rd = 0; rs1 = 0; u1 = 1; step();
    rd = 7; rs1 = 7; u1 = 0; step();
    idle(); step();
    // branch beats load-use
    mr = 1; rd = 5; rs2 = 5; u2 = 1; br = 1; step();
    idle(); step();
    // memory wait with a pending jalr
    req = 1; rdy = 0; jr = 1; repeat (3) step();
    rdy = 1; step();
    idle(); step();
    // stall counter saturation, then clear under a stall
    mr = 1; rd = 3; rs1 = 3; u1 = 1; repeat (5) step();
    clr = 1; step();
    idle(); step();
    // watchdog expiry, sticky error, reset out of it
    req = 1; rdy = 0; repeat (6) step();
    rdy = 1; repeat (2) step();
    rst_n = 0; step();
    rst_n = 1; idle(); step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      u1  = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      mr  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 7) == 0);
      jj  = ($urandom_range(0, 15) == 0);
      jr  = ($urandom_range(0, 15) == 0);
      req = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1; idle();
    for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      total++; bad++;
      $display("FAIL drain left=%0d want=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates all stall, hold, flush and redirect strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from ID/EX-stage control fields and the data-memory handshake. It detects load-use hazards, waits on slow data memory with a watchdog, and squashes wrong-path instructions on taken branches and jumps. Saturating stall and flush event counters support performance analysis.

Parameters:
TIMEOUT, 255, max consecutive MEM_WAIT cycles before the error state; 0 disables the watchdog.
CNT_W, 16, width of the event counters.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous reset, active-low
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mr  in  1  EX-stage instruction is a load (ID/EX mr field)
ex_regdest  in  5  EX-stage destination register
ex_br_taken  in  1  EX branch resolved taken
ex_j  in  1  EX-stage jal
ex_jr  in  1  EX-stage jalr
mem_req  in  1  MEM stage issues a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
clr_cnt  in  1  synchronous clear of both counters
pc_write  out  1  PC register enable
pc_redirect  out  1  select branch/jump target for next PC
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to bubble
idex_flush  out  1  ID/EX clear to bubble (drives its flush input)
pipe_hold  out  1  hold ID/EX and EX/MEM contents
memwb_bubble  out  1  write bubble (rw=0) into MEM/WB
mem_timeout  out  1  sticky watchdog error
state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
stall_cnt  out  CNT_W  stall cycles (load-use plus MEM_WAIT)
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (reset=0, asynchronous): state=RUN; wait_cnt, stall_cnt, flush_cnt=0; mem_timeout=0. While reset is low, force pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pc_redirect=0, pipe_hold=0, memwb_bubble=0.
- Strobes are combinational from state and current inputs (zero latency). Counters, wait_cnt and state are registered.
- Default in RUN: pc_write=1, ifid_write=1, all other strobes 0.
- mem_stall = mem_req & ~mem_ready.
- redirect = ex_br_taken | ex_j | ex_jr.
- load_use = ex_mr & (ex_regdest!=0) & ((id_use_rs1 & id_rs1==ex_regdest) | (id_use_rs2 & id_rs2==ex_regdest)).
- Priority in RUN: mem_stall > redirect > load_use.
  - mem_stall: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1. Next state MEM_WAIT, wait_cnt<=1, stall_cnt+1. Any redirect is ignored here; EX is frozen, so it is re-presented on exit.
  - redirect: pc_redirect=1, ifid_flush=1, idex_flush=1, flush_cnt+1. A simultaneous load_use is discarded because the ID instruction is squashed.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1, stall_cnt+1. Lasts exactly one cycle, since the load advances to MEM.
- MEM_WAIT: strobes as for mem_stall, stall_cnt+1 each cycle.
  - When mem_ready=1: that cycle behaves as RUN evaluated with mem_stall=0 (redirect/load_use honoured). Next state RUN, wait_cnt<=0. The completing cycle is not counted as a stall.
  - When mem_ready=0 and TIMEOUT!=0 and wait_cnt==TIMEOUT: next state ERROR, mem_timeout<=1.
  - Otherwise wait_cnt+1, saturating at TIMEOUT.
- ERROR: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1, mem_timeout=1. Counters frozen. Exit only via reset.
- Counters saturate at all-ones. clr_cnt has priority over increment in the same cycle.
- ex_regdest==0 never produces load_use (x0).
- state encoding 3 is unreachable; treat it as ERROR.

Test Plan:
- Load-use: ex_mr=1, ex_regdest=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1, stall_cnt=1; next cycle ex_mr=0 -> defaults restored.
- x0 / unused source: ex_mr=1, ex_regdest=0, id_rs1=0, id_use_rs1=1 -> no stall; ex_regdest=7, id_rs1=7, id_use_rs1=0 -> no stall.
- Branch vs load-use: ex_br_taken=1 with load_use also true -> pc_redirect=1, ifid_flush=1, idex_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high, with ex_jr=1 throughout -> state=MEM_WAIT for 3 cycles, pipe_hold=1, stall_cnt=3; ready cycle asserts pc_redirect=1, flush_cnt=1, state returns to RUN.
- Watchdog: TIMEOUT=4, mem_req=1, mem_ready=0 held -> ERROR entered after 5th wait cycle, mem_timeout=1, stays set after mem_ready=1; reset low mid-ERROR -> state=RUN, counters 0, mem_timeout=0 immediately.
- Counter saturation and clear: CNT_W=2, 5 load-use stalls -> stall_cnt=3; clr_cnt=1 concurrent with a stall -> stall_cnt=0.
